// File: rtl/accel_dispatch_queue_if.sv
// Handshake bundle between the issue stage, the dispatch queue and the accelerator channels.
// The queue connects through the slave modport; the issue/accelerator side uses master.
interface accel_dispatch_queue_if #(
    parameter int NrChannels  = 2,
    parameter int TransIdBits = 3,
    parameter int OpWidth     = 8,
    parameter int XLEN        = 64
);
    localparam int ChanW = (NrChannels > 1) ? $clog2(NrChannels) : 1;

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [ChanW-1:0]       in_chan_i;
    logic [TransIdBits-1:0] in_trans_id_i;
    logic [OpWidth-1:0]     in_op_i;
    logic [XLEN-1:0]        in_rs1_i;
    logic [XLEN-1:0]        in_rs2_i;

    logic [NrChannels-1:0]  acc_valid_o;
    logic [NrChannels-1:0]  acc_ready_i;
    logic [TransIdBits-1:0] acc_trans_id_o;
    logic [OpWidth-1:0]     acc_op_o;
    logic [XLEN-1:0]        acc_rs1_o;
    logic [XLEN-1:0]        acc_rs2_o;
    logic [NrChannels-1:0]  acc_done_i;

    modport slave (
        input  in_valid_i, in_chan_i, in_trans_id_i, in_op_i, in_rs1_i, in_rs2_i,
        output in_ready_o,
        output acc_valid_o, acc_trans_id_o, acc_op_o, acc_rs1_o, acc_rs2_o,
        input  acc_ready_i, acc_done_i
    );

    modport master (
        output in_valid_i, in_chan_i, in_trans_id_i, in_op_i, in_rs1_i, in_rs2_i,
        input  in_ready_o,
        input  acc_valid_o, acc_trans_id_o, acc_op_o, acc_rs1_o, acc_rs2_o,
        output acc_ready_i, acc_done_i
    );
endinterface

// File: rtl/accel_dispatch_queue.sv
// In-order queue from the issue stage to the accelerator channels, with a per-channel
// credit counter limiting how many ops each channel may have in flight.
module accel_dispatch_queue #(
    parameter int NrChannels     = 2,
    parameter int Depth          = 4,
    parameter int MaxOutstanding = 2,
    parameter int TransIdBits    = 3,
    parameter int OpWidth        = 8,
    parameter int XLEN           = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   stall_i,
    accel_dispatch_queue_if.slave  bus,
    output logic [$clog2(Depth):0] count_o,
    output logic                   err_o
);
    localparam int PtrW  = $clog2(Depth);
    localparam int ChanW = (NrChannels > 1) ? $clog2(NrChannels) : 1;
    localparam int CredW = $clog2(MaxOutstanding + 1);
    localparam logic [ChanW:0]   NrChanL = (ChanW + 1)'(NrChannels);
    localparam logic [CredW-1:0] MaxCred = CredW'(MaxOutstanding);

    typedef struct packed {
        logic [ChanW-1:0]       chan;
        logic [TransIdBits-1:0] id;
        logic [OpWidth-1:0]     op;
        logic [XLEN-1:0]        rs1;
        logic [XLEN-1:0]        rs2;
    } entry_t;

    entry_t                r_mem [Depth];
    logic [PtrW:0]         r_wr;
    logic [PtrW:0]         r_rd;
    logic [CredW-1:0]      r_cred [NrChannels];
    logic                  r_err;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_inReady;
    logic                  w_hs;
    logic                  w_chanOk;
    logic                  w_push;
    logic                  w_pop;
    entry_t                w_head;
    logic [NrChannels-1:0] w_accValid;
    logic [NrChannels-1:0] w_disp;

    // Ready is held low while reset is asserted; flush swallows a same-cycle handshake.
    always_comb begin
        w_empty   = (r_wr == r_rd);
        w_full    = (r_wr[PtrW] != r_rd[PtrW]) && (r_wr[PtrW-1:0] == r_rd[PtrW-1:0]);
        w_head    = r_mem[r_rd[PtrW-1:0]];
        w_inReady = rst_ni && !w_full;
        w_hs      = bus.in_valid_i && w_inReady && !flush_i;
        w_chanOk  = ({1'b0, bus.in_chan_i} < NrChanL);
        w_push    = w_hs && w_chanOk;
        w_accValid = '0;
        for (int c = 0; c < NrChannels; c++) begin
            w_accValid[c] = !w_empty && (w_head.chan == ChanW'(c)) && !stall_i &&
                            !flush_i && (r_cred[c] < MaxCred);
        end
        w_disp = w_accValid & bus.acc_ready_i;
        w_pop  = |w_disp;
    end

    always_comb begin
        bus.in_ready_o     = w_inReady;
        bus.acc_valid_o    = w_accValid;
        bus.acc_trans_id_o = w_empty ? '0 : w_head.id;
        bus.acc_op_o       = w_empty ? '0 : w_head.op;
        bus.acc_rs1_o      = w_empty ? '0 : w_head.rs1;
        bus.acc_rs2_o      = w_empty ? '0 : w_head.rs2;
        count_o            = r_wr - r_rd;
        err_o              = r_err;
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr[PtrW-1:0]] <= '{chan: bus.in_chan_i, id: bus.in_trans_id_i,
                                       op: bus.in_op_i, rs1: bus.in_rs1_i, rs2: bus.in_rs2_i};
        end
    end

    // Credits survive a flush: ops already handed to a channel still complete.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_err <= 1'b0;
            for (int c = 0; c < NrChannels; c++) begin
                r_cred[c] <= '0;
            end
        end else begin
            if (flush_i) begin
                r_rd <= r_wr;
            end else begin
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop)  r_rd <= r_rd + 1'b1;
            end
            if (w_hs && !w_chanOk) r_err <= 1'b1;
            for (int c = 0; c < NrChannels; c++) begin
                if (w_disp[c] && !bus.acc_done_i[c]) begin
                    r_cred[c] <= r_cred[c] + 1'b1;
                end else if (!w_disp[c] && bus.acc_done_i[c]) begin
                    if (r_cred[c] == '0) r_err <= 1'b1;
                    else                 r_cred[c] <= r_cred[c] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_accel_dispatch_queue.sv
// Directed bench for accel_dispatch_queue: a scoreboard records accepted ops and checks
// each dispatch in order; directed steps check credits, back-pressure, flush and reset.
module tb_accel_dispatch_queue;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       stall_i;
    logic [2:0] count;
    logic       err;
    logic [2:0] count3;
    logic       err3;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        chan;
        logic [2:0]  id;
        logic [7:0]  op;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } sb_t;

    sb_t sbQ[$];
    sb_t e;

    always #5 clk_i = ~clk_i;

    accel_dispatch_queue_if #(.NrChannels(2), .TransIdBits(3), .OpWidth(8), .XLEN(64)) bus ();
    accel_dispatch_queue_if #(.NrChannels(3), .TransIdBits(3), .OpWidth(8), .XLEN(64)) bus3 ();

    accel_dispatch_queue #(
        .NrChannels(2), .Depth(4), .MaxOutstanding(2), .TransIdBits(3), .OpWidth(8), .XLEN(64)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .stall_i(stall_i),
        .bus(bus), .count_o(count), .err_o(err)
    );

    accel_dispatch_queue #(
        .NrChannels(3), .Depth(4), .MaxOutstanding(2), .TransIdBits(3), .OpWidth(8), .XLEN(64)
    ) dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .stall_i(stall_i),
        .bus(bus3), .count_o(count3), .err_o(err3)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input logic chan, input logic [2:0] id);
        bus.in_valid_i    = 1'b1;
        bus.in_chan_i     = chan;
        bus.in_trans_id_i = id;
        bus.in_op_i       = {5'h15, id};
        bus.in_rs1_i      = {$urandom, $urandom};
        bus.in_rs2_i      = {$urandom, $urandom};
        tick();
        bus.in_valid_i    = 1'b0;
    endtask

    // Scoreboard: expected ops enter on an accepted handshake and leave on dispatch.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sbQ.delete();
        end else begin
            if (|(bus.acc_valid_o & bus.acc_ready_i)) begin
                checkOutput("sb_has_entry", 64'(sbQ.size() != 0), 64'd1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    checkOutput("disp_onehot", 64'(bus.acc_valid_o), 64'(1) << e.chan);
                    checkOutput("disp_id", 64'(bus.acc_trans_id_o), 64'(e.id));
                    checkOutput("disp_op", 64'(bus.acc_op_o), 64'(e.op));
                    checkOutput("disp_rs1", bus.acc_rs1_o, e.rs1);
                    checkOutput("disp_rs2", bus.acc_rs2_o, e.rs2);
                end
            end
            if (flush_i) sbQ.delete();
            else if (bus.in_valid_i && bus.in_ready_o) begin
                sbQ.push_back('{chan: bus.in_chan_i, id: bus.in_trans_id_i, op: bus.in_op_i,
                                rs1: bus.in_rs1_i, rs2: bus.in_rs2_i});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        bus.in_valid_i = 1'b0; bus.in_chan_i = '0; bus.in_trans_id_i = '0;
        bus.in_op_i = '0; bus.in_rs1_i = '0; bus.in_rs2_i = '0;
        bus.acc_ready_i = '0; bus.acc_done_i = '0;
        bus3.in_valid_i = 1'b0; bus3.in_chan_i = '0; bus3.in_trans_id_i = '0;
        bus3.in_op_i = '0; bus3.in_rs1_i = '0; bus3.in_rs2_i = '0;
        bus3.acc_ready_i = '0; bus3.acc_done_i = '0;

        // Reset state
        #2;
        checkOutput("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        checkOutput("rst_acc_valid", 64'(bus.acc_valid_o), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        tick();
        rst_ni = 1'b1;
        settle();
        checkOutput("post_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        checkOutput("post_rst_trans_id", 64'(bus.acc_trans_id_o), 64'd0);
        checkOutput("post_rst_rs1", bus.acc_rs1_o, 64'd0);
        checkOutput("post_rst_err3", 64'(err3), 64'd0);

        // Credit limit: ids 0,1 go out on ch0, then the channel runs out of credits
        tick();
        bus.acc_ready_i = 2'b01;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'(i));
        settle();
        checkOutput("credit_block_valid", 64'(bus.acc_valid_o), 64'd0);
        checkOutput("credit_block_count", 64'(count), 64'd2);
        tick();
        bus.acc_done_i = 2'b01;
        tick();
        bus.acc_done_i = 2'b00;
        settle();
        checkOutput("credit_return_valid", 64'(bus.acc_valid_o), 64'd1);
        checkOutput("credit_return_id", 64'(bus.acc_trans_id_o), 64'd2);
        tick();
        bus.acc_done_i = 2'b01;
        tick(); tick(); tick();
        bus.acc_done_i = 2'b00;
        settle();
        checkOutput("t1_drained_count", 64'(count), 64'd0);
        checkOutput("t1_err", 64'(err), 64'd0);

        // Full queue back-pressure
        tick();
        bus.acc_ready_i = 2'b00;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'(i));
        settle();
        checkOutput("full_in_ready", 64'(bus.in_ready_o), 64'd0);
        checkOutput("full_count", 64'(count), 64'd4);
        tick();
        applyStimulus(1'b0, 3'd7);
        settle();
        checkOutput("full_reject_count", 64'(count), 64'd4);
        tick();
        bus.acc_ready_i = 2'b01;
        settle();
        checkOutput("full_pop_valid", 64'(bus.acc_valid_o), 64'd1);
        tick();
        bus.acc_ready_i = 2'b00;
        settle();
        checkOutput("after_pop_count", 64'(count), 64'd3);
        checkOutput("after_pop_in_ready", 64'(bus.in_ready_o), 64'd1);
        tick();
        bus.acc_ready_i = 2'b01;
        bus.acc_done_i  = 2'b01;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (count == 3'd0) break;
        end
        checkOutput("t2_drain", 64'(count), 64'd0);
        tick();
        bus.acc_done_i  = 2'b00;
        bus.acc_ready_i = 2'b00;

        // In-order hold: ch1 head blocks a ready ch0 op; stall also blocks
        bus.acc_ready_i = 2'b01;
        applyStimulus(1'b1, 3'd4);
        applyStimulus(1'b0, 3'd5);
        settle();
        checkOutput("hold_valid", 64'(bus.acc_valid_o), 64'h2);
        checkOutput("hold_id", 64'(bus.acc_trans_id_o), 64'd4);
        checkOutput("hold_count", 64'(count), 64'd2);
        stall_i = 1'b1;
        #1;
        checkOutput("stall_valid", 64'(bus.acc_valid_o), 64'd0);
        stall_i = 1'b0;
        tick();
        bus.acc_ready_i = 2'b11;
        tick(); tick();
        settle();
        checkOutput("t3_drain", 64'(count), 64'd0);
        tick();
        bus.acc_ready_i = 2'b00;
        bus.acc_done_i  = 2'b11;
        tick();
        bus.acc_done_i  = 2'b00;

        // Flush with one op in flight keeps its credit
        bus.acc_ready_i = 2'b01;
        applyStimulus(1'b0, 3'd0);
        tick();
        bus.acc_ready_i = 2'b00;
        for (int i = 1; i < 4; i++) applyStimulus(1'b0, 3'(i));
        settle();
        checkOutput("pre_flush_count", 64'(count), 64'd3);
        tick();
        flush_i = 1'b1;
        bus.acc_ready_i = 2'b01;
        bus.in_valid_i = 1'b1; bus.in_chan_i = 1'b0; bus.in_trans_id_i = 3'd7;
        settle();
        checkOutput("flush_no_disp", 64'(bus.acc_valid_o), 64'd0);
        tick();
        flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.acc_ready_i = 2'b00;
        settle();
        checkOutput("flush_count", 64'(count), 64'd0);
        tick();
        bus.acc_done_i = 2'b01;
        tick();
        bus.acc_done_i = 2'b00;
        settle();
        checkOutput("flush_credit_kept", 64'(err), 64'd0);

        // Credit underflow on ch1 and bad channel on the three-channel instance
        tick();
        bus.acc_done_i = 2'b10;
        tick();
        bus.acc_done_i = 2'b00;
        settle();
        checkOutput("underflow_err", 64'(err), 64'd1);
        tick();
        bus.acc_ready_i = 2'b10;
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd2);
        tick();
        settle();
        checkOutput("underflow_credit_zero", 64'(count), 64'd0);
        tick();
        bus.acc_ready_i = 2'b00;
        bus.acc_done_i  = 2'b10;
        tick(); tick();
        bus.acc_done_i  = 2'b00;
        settle();
        checkOutput("err_sticky", 64'(err), 64'd1);
        tick();
        bus3.in_valid_i = 1'b1; bus3.in_chan_i = 2'd3; bus3.in_trans_id_i = 3'd6;
        settle();
        checkOutput("badchan_ready", 64'(bus3.in_ready_o), 64'd1);
        tick();
        bus3.in_chan_i = 2'd2;
        settle();
        checkOutput("badchan_count", 64'(count3), 64'd0);
        checkOutput("badchan_err", 64'(err3), 64'd1);
        tick();
        bus3.in_valid_i = 1'b0;
        settle();
        checkOutput("ch2_count", 64'(count3), 64'd1);
        checkOutput("ch2_valid", 64'(bus3.acc_valid_o), 64'h4);

        // Asynchronous reset in the middle of a pending dispatch
        tick();
        applyStimulus(1'b0, 3'd5);
        settle();
        checkOutput("pre_rst_valid", 64'(bus.acc_valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(bus.acc_valid_o), 64'd0);
        checkOutput("async_rst_count", 64'(count), 64'd0);
        checkOutput("async_rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        checkOutput("async_rst_err", 64'(err), 64'd0);
        checkOutput("async_rst_id", 64'(bus.acc_trans_id_o), 64'd0);
        tick(); tick();
        rst_ni = 1'b1;
        settle();
        checkOutput("sb_empty_at_end", 64'(sbQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
